// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op widths, op codes and controller FSM states
package alu_pkg;
  localparam int ALU_SELW = 3;
  localparam logic [ALU_SELW-1:0] ALU_ADD = 3'd0;
  localparam logic [ALU_SELW-1:0] ALU_SUB = 3'd1;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick, ties go to the requester that was not last_owner
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_owner,
  output logic grant0,
  output logic grant1
);
  assign grant0 = valid0 && (!valid1 || last_owner);
  assign grant1 = valid1 && (!valid0 || !last_owner);
endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one external ALU between two requesters with round-robin arbitration
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int W    = 32,
  parameter int SELW = ALU_SELW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [W-1:0]    req0_rs1,
  input  logic [W-1:0]    req0_rs2,
  input  logic [SELW-1:0] req0_sel,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [W-1:0]    req1_rs1,
  input  logic [W-1:0]    req1_rs2,
  input  logic [SELW-1:0] req1_sel,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [W-1:0]    rsp_data,
  output logic            rsp_msb,
  output logic [W-1:0]    alu_rs1,
  output logic [W-1:0]    alu_rs2,
  output logic [SELW-1:0] alu_sel,
  input  logic [W-1:0]    alu_sal,
  input  logic            alu_msb,
  output logic            busy
);
  state_t state, nxt;
  logic owner, last_owner, grant0, grant1, accept, rsp_hs;

  rr_arb2 u_arb (
    .valid0    (req0_valid),
    .valid1    (req1_valid),
    .last_owner(last_owner),
    .grant0    (grant0),
    .grant1    (grant1)
  );

  // ready is gated by rst so nothing looks accepted while reset is asserted
  assign req0_ready = !rst && state == IDLE && grant0;
  assign req1_ready = !rst && state == IDLE && grant1;
  assign accept     = req0_ready || req1_ready;
  assign rsp0_valid = state == RESP && !owner;
  assign rsp1_valid = state == RESP && owner;
  assign rsp_hs     = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
  assign busy       = state != IDLE;

  always_comb begin
    nxt = state;
    if (state == IDLE) nxt = accept ? EXEC : IDLE;
    else if (state == EXEC) nxt = RESP;
    else nxt = rsp_hs ? IDLE : RESP;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      alu_rs1    <= '0;
      alu_rs2    <= '0;
      alu_sel    <= '0;
      rsp_data   <= '0;
      rsp_msb    <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        owner   <= grant1;
        alu_rs1 <= grant1 ? req1_rs1 : req0_rs1;
        alu_rs2 <= grant1 ? req1_rs2 : req0_rs2;
        alu_sel <= grant1 ? req1_sel : req0_sel;
      end
      if (state == EXEC) begin
        rsp_data <= alu_sal;
        rsp_msb  <= alu_msb;
      end
      if (rsp_hs) last_owner <= owner;
    end
  end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed vectors, corner sequences and randomized transaction-level model check
module tb_alu_share_ctrl;
  import alu_pkg::*;
  logic clk = 0, rst = 1;
  logic req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_msb, busy, alu_msb;
  logic [31:0] req0_rs1 = 0, req0_rs2 = 0, req1_rs1 = 0, req1_rs2 = 0;
  logic [2:0] req0_sel = 0, req1_sel = 0, alu_sel;
  logic [31:0] rsp_data, alu_rs1, alu_rs2, alu_sal;
  int checks = 0, errors = 0, cyc = 0;

  alu_share_ctrl #(.W(32), .SELW(3)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rs1(req0_rs1), .req0_rs2(req0_rs2), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req1_sel(req1_sel),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_msb(rsp_msb),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_sel(alu_sel), .alu_sal(alu_sal), .alu_msb(alu_msb),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [2:0] s);
    case (s)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << b[4:0];
      3'd6: return a >> b[4:0];
      default: return {31'd0, a < b};
    endcase
  endfunction

  assign alu_sal = alu_f(alu_rs1, alu_rs2, alu_sel);
  assign alu_msb = alu_sal[31];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset;
    rst = 1;
    step;
    step;
    rst = 0;
  endtask

  task automatic txn(input bit k, input logic [31:0] a, input logic [31:0] b, input logic [2:0] s,
                     input logic [31:0] ed, input bit em, input int hold);
    int n;
    logic [31:0] sal_s;
    logic [31:0] held;
    n = 0;
    if (k) begin req1_valid = 1; req1_rs1 = a; req1_rs2 = b; req1_sel = s; end
    else begin req0_valid = 1; req0_rs1 = a; req0_rs2 = b; req0_sel = s; end
    #1;
    while (!(k ? req1_ready : req0_ready) && n < 20) begin step; n++; end
    if (n == 20) chk("accept_timeout", 32'd0, 32'd1);
    step;
    req0_valid = 0;
    req1_valid = 0;
    chk("exec_busy", {31'd0, busy}, 32'd1);
    chk("exec_alu_rs1", alu_rs1, a);
    chk("exec_alu_sel", {29'd0, alu_sel}, {29'd0, s});
    chk("exec_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    sal_s = alu_sal;
    step;
    chk("rsp_valid_owner", {30'd0, rsp1_valid, rsp0_valid}, k ? 32'd2 : 32'd1);
    chk("rsp_data", rsp_data, ed);
    chk("rsp_msb", {31'd0, rsp_msb}, {31'd0, em});
    chk("rsp_eq_exec_sal", rsp_data, sal_s);
    held = rsp_data;
    repeat (hold) begin
      step;
      chk("hold_valid", {30'd0, rsp1_valid, rsp0_valid}, k ? 32'd2 : 32'd1);
      chk("hold_data", rsp_data, held);
    end
    if (k) rsp1_ready = 1; else rsp0_ready = 1;
    step;
    rsp0_ready = 0;
    rsp1_ready = 0;
    chk("rsp_done", {29'd0, busy, rsp1_valid, rsp0_valid}, 32'd0);
  endtask

  typedef struct {
    bit k;
    logic [31:0] a, b;
    logic [2:0] s;
    logic [31:0] d;
    bit m;
    int hold;
  } vec_t;
  vec_t tv[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int acc_cyc[$];
    bit acc_own[$];
    bit last_acc;
    int n;
    tv[0] = '{0, 32'd5812, 32'd6352, ALU_ADD, 32'd12164, 0, 0};
    tv[1] = '{1, 32'd5812, 32'd6352, ALU_SUB, 32'hFFFFFDE4, 1, 0};
    tv[2] = '{0, 32'hFFFFFFFF, 32'd1, ALU_ADD, 32'h00000000, 0, 2};
    tv[3] = '{1, 32'h7FFFFFFF, 32'd1, ALU_ADD, 32'h80000000, 1, 0};
    tv[4] = '{0, 32'd0, 32'd1, ALU_SUB, 32'hFFFFFFFF, 1, 3};
    tv[5] = '{1, 32'hA5A5A5A5, 32'h5A5A5A5A, ALU_ADD, 32'hFFFFFFFF, 1, 0};

    #3;
    chk("reset_outputs", {27'd0, req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy}, 32'd0);
    chk("reset_regs", alu_rs1 | alu_rs2 | {29'd0, alu_sel} | rsp_data | {31'd0, rsp_msb}, 32'd0);
    do_reset;

    foreach (tv[i]) txn(tv[i].k, tv[i].a, tv[i].b, tv[i].s, tv[i].d, tv[i].m, tv[i].hold);

    // reset asserted in the middle of EXEC
    req0_valid = 1; req0_rs1 = 32'd77; req0_rs2 = 32'd11; req0_sel = ALU_ADD;
    #1;
    chk("pre_reset_ready", {31'd0, req0_ready}, 32'd1);
    step;
    req0_valid = 0;
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    #1 rst = 1;
    #1;
    chk("async_reset_outputs", {27'd0, req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy}, 32'd0);
    chk("async_reset_regs", alu_rs1 | alu_rs2 | {29'd0, alu_sel} | rsp_data | {31'd0, rsp_msb}, 32'd0);
    step;
    rst = 0;
    rsp0_ready = 1; rsp1_ready = 1;
    n = 0;
    repeat (5) begin
      step;
      n += rsp0_valid + rsp1_valid + busy;
    end
    chk("no_rsp_after_reset", n, 32'd0);
    rsp0_ready = 0; rsp1_ready = 0;

    // tie and fairness: both valid continuously from reset
    do_reset;
    rsp0_ready = 1; rsp1_ready = 1;
    req0_valid = 1; req1_valid = 1;
    req0_rs1 = 32'd1; req0_rs2 = 32'd2; req1_rs1 = 32'd3; req1_rs2 = 32'd4;
    req0_sel = ALU_ADD; req1_sel = ALU_ADD;
    #1;
    last_acc = 0;
    n = 0;
    while (acc_cyc.size() < 4 && n < 40) begin
      if (req0_ready && req1_ready) chk("dual_ready", 32'd1, 32'd0);
      if (req0_ready || req1_ready) begin
        acc_cyc.push_back(cyc);
        acc_own.push_back(req1_ready);
        last_acc = req1_ready;
      end
      if (rsp0_valid || rsp1_valid) begin
        chk("tie_rsp_owner", {30'd0, rsp1_valid, rsp0_valid}, last_acc ? 32'd2 : 32'd1);
        chk("tie_rsp_data", rsp_data, last_acc ? 32'd7 : 32'd3);
      end
      step;
      n++;
    end
    chk("tie_accept_count", acc_cyc.size(), 32'd4);
    foreach (acc_own[i]) chk("tie_grant_order", {31'd0, acc_own[i]}, {31'd0, i[0]});
    for (int i = 1; i < acc_cyc.size(); i++) chk("tie_accept_gap", acc_cyc[i] - acc_cyc[i-1], 32'd3);
    req0_valid = 0; req1_valid = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    step; step; step;

    // backpressure on rsp0 while req1 keeps asking
    do_reset;
    req0_valid = 1; req1_valid = 1;
    req0_rs1 = 32'd100; req0_rs2 = 32'd30; req0_sel = ALU_SUB;
    #1;
    chk("bp_req0_wins", {30'd0, req1_ready, req0_ready}, 32'd1);
    step;
    req0_valid = 0;
    step;
    chk("bp_rsp0_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd1);
    chk("bp_data", rsp_data, 32'd70);
    repeat (5) begin
      step;
      chk("bp_data_stable", rsp_data, 32'd70);
      chk("bp_req1_blocked", {31'd0, req1_ready}, 32'd0);
      chk("bp_rsp0_held", {30'd0, rsp1_valid, rsp0_valid}, 32'd1);
    end
    rsp1_ready = 1;
    step;
    chk("bp_nonowner_ignored", {30'd0, rsp1_valid, rsp0_valid}, 32'd1);
    rsp1_ready = 0;
    rsp0_ready = 1;
    step;
    rsp0_ready = 0;
    chk("bp_req1_after_hs", {31'd0, req1_ready}, 32'd1);
    req1_valid = 0;
    step;

    // sel sweep 0..7 through requester 0
    do_reset;
    for (int s = 0; s < 8; s++)
      txn(0, 32'hF0F0_1234, 32'd5, s[2:0], alu_f(32'hF0F0_1234, 32'd5, s[2:0]),
          alu_f(32'hF0F0_1234, 32'd5, s[2:0]) >> 31 != 0, s % 2);

    // randomized traffic against a transaction-level model
    do_reset;
    begin
      bit out, m_owner, m_last, a0, a1, rhs, er0, er1, ev0, ev1;
      int m_acc;
      logic [31:0] m_data;
      out = 0; m_owner = 0; m_last = 1; m_acc = 0; m_data = 0;
      for (int i = 0; i < 3000; i++) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req1_valid = ($urandom_range(0, 3) != 0);
        req0_rs1 = $urandom; req0_rs2 = $urandom; req0_sel = 3'($urandom_range(0, 7));
        req1_rs1 = $urandom; req1_rs2 = $urandom; req1_sel = 3'($urandom_range(0, 7));
        rsp0_ready = $urandom_range(0, 1) != 0;
        rsp1_ready = $urandom_range(0, 1) != 0;
        #1;
        if (out) begin er0 = 0; er1 = 0; end
        else if (req0_valid && req1_valid) begin er0 = m_last; er1 = !m_last; end
        else begin er0 = req0_valid; er1 = req1_valid; end
        chk("rnd_ready", {30'd0, req1_ready, req0_ready}, {30'd0, er1, er0});
        ev0 = out && !m_owner && cyc >= m_acc + 2;
        ev1 = out && m_owner && cyc >= m_acc + 2;
        chk("rnd_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, {30'd0, ev1, ev0});
        if (ev0 || ev1) begin
          chk("rnd_rsp_data", rsp_data, m_data);
          chk("rnd_rsp_msb", {31'd0, rsp_msb}, {31'd0, m_data[31]});
        end
        a0 = er0; a1 = er1;
        rhs = (ev0 && rsp0_ready) || (ev1 && rsp1_ready);
        if (rhs) begin out = 0; m_last = m_owner; end
        if (a0 || a1) begin
          out = 1; m_owner = a1; m_acc = cyc;
          m_data = a1 ? alu_f(req1_rs1, req1_rs2, req1_sel) : alu_f(req0_rs1, req0_rs2, req0_sel);
        end
        step;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
